// File: rtl/mem_if_pkg.sv
// Shared request/response layout for the L3 memory queue; imported by both
// the cache side and the main-memory responder.
package mem_if_pkg;
  localparam int REQ_W   = 89;
  localparam int RSP_W   = 88;
  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 64;
  localparam int RW_BIT  = 88;
  localparam int ADDR_HI = 87;
  localparam int ADDR_LO = 64;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;
endpackage

// File: rtl/resp_memoria_principal_fifo_sync.sv
// Generic synchronous FIFO with occupancy count. A push on a full FIFO is
// accepted only when a pop frees a slot on the same edge.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/resp_memoria_principal.sv
// Main-memory responder: queues cache requests, services them against a
// backing line store with fixed latency, returns read lines via valid/ready.
module resp_memoria_principal
  import mem_if_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MEM_AW  = 10,
  parameter int LATENCY = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       Push_Valid,
  input  logic [REQ_W-1:0]           D_PUSH,
  output logic                       Full,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic [RSP_W-1:0]           D_POP,
  output logic                       Pop_Valid,
  input  logic                       Pop_Ready,
  output logic                       Busy
);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t             state;
  logic [REQ_W-1:0]   req;
  logic [REQ_W-1:0]   head;
  logic [CNT_W-1:0]   cnt;
  logic               fifo_empty;
  logic               deq;
  logic               commit;
  logic [MEM_AW-1:0]  idx;
  logic [DATA_W-1:0]  store [2**MEM_AW];

  assign deq    = (state == IDLE) && !fifo_empty;
  assign idx    = req[ADDR_LO+MEM_AW+2 : ADDR_LO+3];
  assign commit = (state == ACCESS) && (cnt == '0) && req[RW_BIT];

  fifo_sync #(
    .WIDTH(REQ_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (CLK),
    .rst  (RESET),
    .push (Push_Valid),
    .din  (D_PUSH),
    .pop  (deq),
    .dout (head),
    .full (Full),
    .empty(fifo_empty),
    .count(Count)
  );

  // Store has no reset; commit drops as soon as RESET forces state to IDLE.
  always_ff @(posedge CLK) begin
    if (commit) store[idx] <= req[DATA_W-1:0];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      req       <= '0;
      cnt       <= '0;
      D_POP     <= '0;
      Pop_Valid <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (deq) begin
            req   <= head;
            cnt   <= CNT_W'(LATENCY - 1);
            state <= ACCESS;
            Busy  <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (req[RW_BIT]) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else begin
            D_POP     <= {req[ADDR_HI:ADDR_LO], store[idx]};
            Pop_Valid <= 1'b1;
            state     <= RESPOND;
          end
        end
        RESPOND: begin
          if (Pop_Ready) begin
            Pop_Valid <= 1'b0;
            state     <= IDLE;
            Busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_resp_memoria_principal.sv
// Scoreboard bench for resp_memoria_principal: directed requests push expected
// responses; a monitor compares every accepted response in order.
module tb_resp_memoria_principal;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        Push_Valid = 1'b0;
  logic [88:0] D_PUSH = '0;
  logic        Full;
  logic [2:0]  Count;
  logic [87:0] D_POP;
  logic        Pop_Valid;
  logic        Pop_Ready = 1'b0;
  logic        Busy;

  int total = 0;
  int bad   = 0;
  logic [87:0] sb [$];

  resp_memoria_principal #(.DEPTH(4), .MEM_AW(10), .LATENCY(4)) dut (
    .CLK(CLK), .RESET(RESET), .Push_Valid(Push_Valid), .D_PUSH(D_PUSH),
    .Full(Full), .Count(Count), .D_POP(D_POP), .Pop_Valid(Pop_Valid),
    .Pop_Ready(Pop_Ready), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge CLK);
      if (Pop_Valid && Pop_Ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", D_POP, 88'h0);
          if (D_POP == 88'h0) chk("unexpected_resp_valid", {87'h0, Pop_Valid}, 88'h0);
        end else begin
          chk("resp", D_POP, sb.pop_front());
        end
      end
    end
  end

  task automatic push(input logic [88:0] d);
    Push_Valid = 1'b1;
    D_PUSH = d;
    @(posedge CLK); #1;
    Push_Valid = 1'b0;
    D_PUSH = '0;
  endtask

  task automatic wr(input logic [23:0] a, input logic [63:0] d);
    push({1'b1, a, d});
    repeat (7) @(posedge CLK);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    Pop_Ready = 1'b1;
    while (sb.size() != 0 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk(name, 88'(sb.size()), 88'h0);
    repeat (15) @(negedge CLK);
    chk({name, "_idle"}, {85'h0, Count}, 88'h0);
    chk({name, "_busy"}, {87'h0, Busy}, 88'h0);
    @(posedge CLK); #1;
    Pop_Ready = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_count", {85'h0, Count}, 88'h0);
    chk("rst_full", {87'h0, Full}, 88'h0);
    chk("rst_valid", {87'h0, Pop_Valid}, 88'h0);
    chk("rst_busy", {87'h0, Busy}, 88'h0);
    chk("rst_dpop", D_POP, 88'h0);
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Pop_Ready with nothing valid is ignored
    Pop_Ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("idle_ready_valid", {87'h0, Pop_Valid}, 88'h0);
    chk("idle_ready_busy", {87'h0, Busy}, 88'h0);
    Pop_Ready = 1'b0;

    // Write then read, with commit and response timing
    sb.push_back({24'h000040, 64'hDEADBEEF_CAFEF00D});
    push({1'b1, 24'h000040, 64'hDEADBEEF_CAFEF00D});
    push({1'b0, 24'h000040, 64'h0});
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (k == 4) chk("wr_busy_before_commit", {87'h0, Busy}, 88'h1);
      if (k == 5) begin
        chk("wr_commit_idle", {87'h0, Busy}, 88'h0);
        chk("wr_commit_count", {85'h0, Count}, 88'h1);
      end
      if (k == 6) begin
        chk("rd_dequeue_busy", {87'h0, Busy}, 88'h1);
        chk("rd_dequeue_count", {85'h0, Count}, 88'h0);
      end
      if (k == 9) chk("rd_valid_early", {87'h0, Pop_Valid}, 88'h0);
      if (k == 10) chk("rd_valid_on_time", {87'h0, Pop_Valid}, 88'h1);
    end

    // Backpressure: response held stable
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      chk("bp_dpop", D_POP, {24'h000040, 64'hDEADBEEF_CAFEF00D});
      chk("bp_valid", {87'h0, Pop_Valid}, 88'h1);
    end
    @(posedge CLK); #1;
    Pop_Ready = 1'b1;
    @(posedge CLK); #1;
    Pop_Ready = 1'b0;
    @(negedge CLK);
    chk("bp_released", {87'h0, Pop_Valid}, 88'h0);
    chk("bp_released_busy", {87'h0, Busy}, 88'h0);

    // Preload lines for FIFO-full test and prior contents for reset test
    for (int i = 1; i <= 7; i++) wr(24'h000100 + 24'(i * 8), {32'hA5A5A5A5, 32'(i)});
    wr(24'h000080, 64'h2222);

    // FIFO full: six back-to-back reads, sixth dropped
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) sb.push_back({24'hF00100 + 24'(i * 8 + 3), 32'hA5A5A5A5, 32'(i)});
      push({1'b0, 24'hF00100 + 24'(i * 8 + 3), 64'h0});
    end
    @(negedge CLK);
    chk("full_count", {85'h0, Count}, 88'h4);
    chk("full_flag", {87'h0, Full}, 88'h1);
    chk("full_first_valid", {87'h0, Pop_Valid}, 88'h1);

    // Pop the first response, then push on the same edge as the dequeue at full
    @(posedge CLK); #1;
    Pop_Ready = 1'b1;
    @(posedge CLK); #1;
    Pop_Ready = 1'b0;
    sb.push_back({24'hF00100 + 24'(7 * 8 + 3), 32'hA5A5A5A5, 32'(7)});
    push({1'b0, 24'hF00100 + 24'(7 * 8 + 3), 64'h0});
    @(negedge CLK);
    chk("simul_count", {85'h0, Count}, 88'h4);
    chk("simul_full", {87'h0, Full}, 88'h1);
    chk("simul_busy", {87'h0, Busy}, 88'h1);
    drain("full_drain");

    // Reset mid-access of a write: no commit
    push({1'b1, 24'h000080, 64'h1111});
    @(posedge CLK);
    @(posedge CLK);
    #3;
    RESET = 1'b1;
    #1;
    chk("mid_rst_busy", {87'h0, Busy}, 88'h0);
    chk("mid_rst_count", {85'h0, Count}, 88'h0);
    chk("mid_rst_valid", {87'h0, Pop_Valid}, 88'h0);
    chk("mid_rst_dpop", D_POP, 88'h0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    sb.push_back({24'h000080, 64'h2222});
    push({1'b0, 24'h000080, 64'h0});
    drain("rst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/resp_memoria_principal.md
Name: resp_memoria_principal

Overview:
- Main-memory-side responder for the third-level cache's memory queue.
- Accepts 89-bit D_PUSH requests (eviction writes and line-fill reads) from the cache into a small request FIFO.
- Services each request against a backing line store with a fixed access latency.
- Returns 88-bit D_POP read responses (address and 64-bit line) to the cache through a valid/ready handshake.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, at least 2.
- MEM_AW, 10, line-index bits; the backing store holds 2^MEM_AW lines of 64 bits.
- LATENCY, 4, memory access cycles; at least 1.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- Push_Valid  in  1  cache presents a request on D_PUSH.
- D_PUSH  in  89  bit [88] is R_W (1 = write/evict, 0 = read/fill); bits [87:64] are the byte address; bits [63:0] are write data.
- Full  out  1  FIFO holds DEPTH entries.
- Count  out  $clog2(DEPTH+1)  current FIFO occupancy.
- D_POP  out  88  bits [87:64] are the request address; bits [63:0] are the line read.
- Pop_Valid  out  1  D_POP holds a valid read response.
- Pop_Ready  in  1  cache consumes the response.
- Busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (async, RESET=1) clears the following immediately: FIFO pointers, Count=0, Full=0, Pop_Valid=0, D_POP=0, Busy=0, state=IDLE, latency counter=0.
- Reset mid-operation discards all queued and in-flight requests; no write is committed.
- Backing store contents are not cleared by RESET.
- Line index is address[MEM_AW+2:3], giving 8-byte lines. Address bits [2:0] and bits above MEM_AW+2 are ignored for indexing but are echoed unchanged in D_POP[87:64].
- Enqueue: when Push_Valid=1 and Full=0 at a rising edge, D_PUSH is written at the tail.
- Push while Full=1 is dropped: no state change, no overwrite.
- Dequeue happens only in IDLE, when the FIFO is non-empty, taking the head.
- Enqueue and dequeue on the same edge keep Count unchanged. This is legal even when Full=1, because the dequeue frees a slot on that edge; accept the push in that case.
- Full is asserted when Count==DEPTH. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if the FIFO is non-empty, latch the head into the request register, load counter=LATENCY-1, go to ACCESS.
  - ACCESS: while counter>0, decrement. When counter==0:
    - write: store[index] <= data, go to IDLE.
    - read: D_POP <= {addr, store[index]}, Pop_Valid <= 1, go to RESPOND.
  - RESPOND: hold D_POP and Pop_Valid stable. On Pop_Ready=1, clear Pop_Valid and go to IDLE.
- Latency: for a request accepted at edge t into an empty, idle block, the dequeue happens at t+1. A read asserts Pop_Valid after edge t+1+LATENCY; a write commits at the same edge.
- Ordering is strictly FIFO. A read after a write to the same line returns the new data.
- Pop_Ready while Pop_Valid=0 is ignored.
- Throughput is one request per LATENCY+1 cycles, plus handshake wait time for reads.
- FIFO enqueue continues during ACCESS and RESPOND.

Decomposition:
- Shared package mem_if_pkg holds:
  - REQ_W=89, RSP_W=88, ADDR_W=24, DATA_W=64.
  - Field offset constants: RW_BIT=88, ADDR_HI=87, ADDR_LO=64.
  - State enum {IDLE, ACCESS, RESPOND}.
- The cache side imports the same package.
- One sub-module: fifo_sync, a generic synchronous FIFO parameterised by width and depth, providing full, count, push and pop.
- The FSM, counter and backing store stay in the top level.

Test Plan:
- Reset then idle: after RESET pulse → Count=0, Full=0, Pop_Valid=0, Busy=0, D_POP=0.
- Write then read: push write {1, 24'h000040, 64'hDEADBEEF_CAFEF00D}, then read {0, 24'h000040, 0} → write commits 5 edges after acceptance; Pop_Valid rises 10 edges after the first push, with D_POP = {24'h000040, 64'hDEADBEEF_CAFEF00D}.
- Backpressure: hold Pop_Ready=0 for 20 cycles during a read response → D_POP stable and Pop_Valid=1 throughout; one cycle of Pop_Ready=1 clears Pop_Valid and the next request starts.
- FIFO full: push 6 reads back-to-back while the first waits in RESPOND → Count peaks at 4 with Full=1, the 6th push is dropped, and exactly 5 responses return in order, with addresses matching the pushes.
- Simultaneous push/pop at Full: Full=1 and IDLE dequeue on the same edge as Push_Valid=1 → push accepted, Count stays 4.
- Reset mid-access: assert RESET during ACCESS of write {1, 24'h000080, 64'h1111} → after reset, a read of 24'h000080 returns the prior contents, not 64'h1111.
